ckv_win_counter: RTL and testbench



---
 rtl/ckv_win_counter.sv | 134 +++++++++++++
 tb/tb_ckv_win_counter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ckv_win_counter.sv
// CKVD-domain window counter feeding the AFC SAR frequency compare.
// Counts CLKSMP cycles while the synchronized REF gate is high, then holds the
// result behind a four-phase RDY/ACK handshake for the REF-domain consumer.
module ckv_win_counter #(
   parameter int unsigned CNT_W       = 18,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             CLKSMP,
   input  logic             NARST,
   input  logic             EN,
   input  logic             GATE,
   input  logic             ACK,
   output logic [CNT_W-1:0] CNT_OUT,
   output logic             RDY,
   output logic             OVF,
   output logic             MISS,
   output logic             BUSY
);

   typedef enum logic [1:0] {StIdle, StCount, StHold, StAckLow} state_e;

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   logic [SYNC_STAGES-1:0] gate_sync_q;
   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic                   gate_d_q;
   logic                   gate_s;
   logic                   ack_s;
   logic                   rise;
   logic                   fall;

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   ovf_flag_q;
   logic [CNT_W-1:0]       cnt_out_q;
   logic                   rdy_q;
   logic                   ovf_q;
   logic                   miss_q;
   logic                   busy_q;

   // Input synchronizers and gate edge history; free-running regardless of EN.
   always_ff @(posedge CLKSMP or negedge NARST) begin
      if (!NARST) begin
         gate_sync_q <= '0;
         ack_sync_q  <= '0;
         gate_d_q    <= 1'b0;
      end else begin
         gate_sync_q <= {gate_sync_q[SYNC_STAGES-2:0], GATE};
         ack_sync_q  <= {ack_sync_q[SYNC_STAGES-2:0], ACK};
         gate_d_q    <= gate_s;
      end
   end

   assign gate_s = gate_sync_q[SYNC_STAGES-1];
   assign ack_s  = ack_sync_q[SYNC_STAGES-1];
   assign rise   = gate_s & ~gate_d_q;
   assign fall   = ~gate_s & gate_d_q;

   // Window FSM with registered outputs; CNT_OUT/OVF only load on COUNT->HOLD.
   always_ff @(posedge CLKSMP or negedge NARST) begin
      if (!NARST) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         ovf_flag_q <= 1'b0;
         cnt_out_q  <= '0;
         rdy_q      <= 1'b0;
         ovf_q      <= 1'b0;
         miss_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else if (!EN) begin
         // CNT_OUT deliberately keeps the last result across disable.
         state_q    <= StIdle;
         cnt_q      <= '0;
         ovf_flag_q <= 1'b0;
         rdy_q      <= 1'b0;
         ovf_q      <= 1'b0;
         miss_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rise) begin
                  cnt_q      <= CntOne;
                  ovf_flag_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= StCount;
               end
            end
            StCount: begin
               if (gate_s) begin
                  if (cnt_q == CntMax) begin
                     ovf_flag_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + CntOne;
                  end
               end else if (fall) begin
                  cnt_out_q <= cnt_q;
                  ovf_q     <= ovf_flag_q;
                  rdy_q     <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= StHold;
               end
            end
            StHold: begin
               // A window opening while the result is unconsumed is dropped.
               if (rise) begin
                  miss_q <= 1'b1;
               end
               if (ack_s) begin
                  rdy_q   <= 1'b0;
                  state_q <= StAckLow;
               end
            end
            StAckLow: begin
               if (rise) begin
                  miss_q <= 1'b1;
               end
               if (!ack_s) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign CNT_OUT = cnt_out_q;
   assign RDY     = rdy_q;
   assign OVF     = ovf_q;
   assign MISS    = miss_q;
   assign BUSY    = busy_q;

endmodule

// File: tb/tb_ckv_win_counter.sv
// Bench for ckv_win_counter: window/handshake scenarios plus random window
// lengths, scored against expected results derived from window length alone.
module tb_ckv_win_counter;

   localparam int unsigned CNT_W       = 8;
   localparam int unsigned SYNC_STAGES = 2;
   localparam int          MaxCnt      = (1 << CNT_W) - 1;
   localparam int          Lat         = SYNC_STAGES + 1;

   logic             CLKSMP = 1'b0;
   logic             NARST;
   logic             EN;
   logic             GATE;
   logic             ACK;
   logic [CNT_W-1:0] CNT_OUT;
   logic             RDY;
   logic             OVF;
   logic             MISS;
   logic             BUSY;

   int n_checks = 0;
   int n_errors = 0;
   int exp_cnt  = 0;
   int exp_ovf  = 0;
   int exp_miss = 0;

   ckv_win_counter #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_dut (
      .CLKSMP  (CLKSMP),
      .NARST   (NARST),
      .EN      (EN),
      .GATE    (GATE),
      .ACK     (ACK),
      .CNT_OUT (CNT_OUT),
      .RDY     (RDY),
      .OVF     (OVF),
      .MISS    (MISS),
      .BUSY    (BUSY)
   );

   always #5 CLKSMP = ~CLKSMP;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Count posedges until RDY reaches lvl; -1 on timeout.
   task automatic wait_rdy(input logic lvl, output int k);
      k = -1;
      for (int i = 1; i <= 20; i++) begin
         @(posedge CLKSMP);
         #1;
         if (RDY === lvl) begin
            k = i;
            break;
         end
      end
   endtask

   // Hold GATE high for n sampling edges, then drop it.
   task automatic drive_window(input int n, input bit busy_exp);
      @(negedge CLKSMP);
      GATE = 1'b1;
      repeat (n) @(posedge CLKSMP);
      if (n >= 4) begin
         #1;
         check_val("busy_in_window", BUSY, busy_exp);
      end
      @(negedge CLKSMP);
      GATE = 1'b0;
   endtask

   task automatic window_and_check(input int n);
      int k;
      drive_window(n, 1'b1);
      wait_rdy(1'b1, k);
      check_val("rdy_rise_lat", k, Lat);
      exp_cnt = (n > MaxCnt) ? MaxCnt : n;
      exp_ovf = (n > MaxCnt) ? 1 : 0;
      check_val("cnt_out", CNT_OUT, exp_cnt);
      check_val("ovf", OVF, exp_ovf);
      check_val("busy_done", BUSY, 0);
      check_val("miss", MISS, exp_miss);
   endtask

   task automatic ack_cycle();
      int k;
      @(negedge CLKSMP);
      ACK = 1'b1;
      wait_rdy(1'b0, k);
      check_val("rdy_fall_lat", k, Lat);
      check_val("cnt_stable", CNT_OUT, exp_cnt);
      @(negedge CLKSMP);
      ACK = 1'b0;
      repeat (SYNC_STAGES + 2) @(negedge CLKSMP);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      NARST = 1'b0;
      EN    = 1'b0;
      GATE  = 1'b0;
      ACK   = 1'b0;
      #1;
      check_val("rst_cnt", CNT_OUT, 0);
      check_val("rst_rdy", RDY, 0);
      check_val("rst_ovf", OVF, 0);
      check_val("rst_miss", MISS, 0);
      check_val("rst_busy", BUSY, 0);
      repeat (3) @(negedge CLKSMP);
      NARST = 1'b1;
      EN    = 1'b1;
      repeat (2) @(negedge CLKSMP);

      // Basic windows and saturation.
      window_and_check(100);
      ack_cycle();
      window_and_check(37);
      ack_cycle();
      window_and_check(300);
      ack_cycle();
      window_and_check(10);

      // Unacknowledged result: next window is dropped and flagged.
      drive_window(50, 1'b0);
      repeat (SYNC_STAGES + 3) @(posedge CLKSMP);
      #1;
      exp_miss = 1;
      check_val("miss_set", MISS, exp_miss);
      check_val("miss_rdy_held", RDY, 1);
      check_val("miss_cnt_held", CNT_OUT, exp_cnt);
      check_val("miss_not_busy", BUSY, 0);
      ack_cycle();
      window_and_check(20);

      // Disable while holding a result: RDY/MISS clear, CNT_OUT kept.
      @(negedge CLKSMP);
      EN = 1'b0;
      @(posedge CLKSMP);
      #1;
      exp_miss = 0;
      check_val("en_rdy_clr", RDY, 0);
      check_val("en_miss_clr", MISS, 0);
      check_val("en_cnt_kept", CNT_OUT, exp_cnt);
      repeat (2) @(negedge CLKSMP);
      EN = 1'b1;
      repeat (2) @(negedge CLKSMP);

      // Disable mid-count.
      GATE = 1'b1;
      repeat (30) @(posedge CLKSMP);
      @(negedge CLKSMP);
      EN = 1'b0;
      @(posedge CLKSMP);
      #1;
      check_val("en_busy_clr", BUSY, 0);
      check_val("en_rdy_low", RDY, 0);
      check_val("en_cnt_kept2", CNT_OUT, exp_cnt);
      @(negedge CLKSMP);
      GATE = 1'b0;
      repeat (5) @(negedge CLKSMP);
      EN = 1'b1;
      repeat (2) @(negedge CLKSMP);
      window_and_check(64);
      ack_cycle();

      // Asynchronous reset mid-window.
      GATE = 1'b1;
      repeat (40) @(posedge CLKSMP);
      @(negedge CLKSMP);
      NARST = 1'b0;
      #1;
      check_val("arst_cnt", CNT_OUT, 0);
      check_val("arst_rdy", RDY, 0);
      check_val("arst_ovf", OVF, 0);
      check_val("arst_miss", MISS, 0);
      check_val("arst_busy", BUSY, 0);
      GATE = 1'b0;
      exp_cnt = 0;
      repeat (3) @(negedge CLKSMP);
      NARST = 1'b1;
      repeat (2) @(negedge CLKSMP);
      window_and_check(100);
      ack_cycle();

      // Single-sample window, then random lengths around the saturation point.
      window_and_check(1);
      ack_cycle();
      for (int i = 0; i < 8; i++) begin
         n = int'($urandom_range(1, 300));
         window_and_check(n);
         ack_cycle();
         repeat ($urandom_range(0, 5)) @(negedge CLKSMP);
      end
      window_and_check(MaxCnt);
      ack_cycle();
      window_and_check(MaxCnt + 1);
      ack_cycle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
